axis_frame_fifo: RTL and testbench



---
 rtl/axis_frame_fifo.sv | 90 +++++++++
 tb/tb_axis_frame_fifo.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/axis_frame_fifo.sv
// axis_frame_fifo: single-clock AXI-Stream FIFO with optional store-and-forward frame mode,
// bad-frame / overflow dropping and committed-occupancy status.
module axis_frame_fifo #(
    parameter int ADDR_WIDTH         = 12,
    parameter int DATA_WIDTH         = 8,
    parameter int FRAME_MODE         = 0,
    parameter int DROP_BAD_FRAME     = 0,
    parameter int DROP_WHEN_FULL     = 0,
    parameter int ALMOST_FULL_THRESH = 2**ADDR_WIDTH - 4
) (
    input  logic                  clk,
    input  logic                  async_rst,
    input  logic [DATA_WIDTH-1:0] input_axis_tdata,
    input  logic                  input_axis_tvalid,
    output logic                  input_axis_tready,
    input  logic                  input_axis_tlast,
    input  logic                  input_axis_tuser,
    output logic [DATA_WIDTH-1:0] output_axis_tdata,
    output logic                  output_axis_tvalid,
    input  logic                  output_axis_tready,
    output logic                  output_axis_tlast,
    output logic                  output_axis_tuser,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  almost_full,
    output logic                  overflow,
    output logic                  bad_frame,
    output logic                  good_frame
);
    localparam int DEPTH = 2**ADDR_WIDTH;
    typedef enum logic {WRITE, DROP} state_t;
    state_t                state_q;
    logic [DATA_WIDTH+1:0] mem [DEPTH];
    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_cur_q, rd_ptr_q;
    logic                  empty, full_cur, accept, store, out_adv, rd_en;
    assign empty    = rd_ptr_q == wr_ptr_q;
    assign full_cur = (wr_ptr_cur_q - rd_ptr_q) == (ADDR_WIDTH+1)'(DEPTH);
    // In drop-capable frame mode the input never stalls; overflowing beats are discarded instead.
    assign input_axis_tready = ~async_rst &
        ((FRAME_MODE != 0 && (DROP_WHEN_FULL != 0 || state_q == DROP)) ? 1'b1 : ~full_cur);
    assign accept      = input_axis_tvalid & input_axis_tready;
    assign store       = accept & ~full_cur & (state_q == WRITE);
    assign out_adv     = output_axis_tready | ~output_axis_tvalid;
    assign rd_en       = out_adv & ~empty;
    assign count       = wr_ptr_q - rd_ptr_q;
    assign almost_full = count >= (ADDR_WIDTH+1)'(ALMOST_FULL_THRESH);
    always_ff @(posedge clk) begin
        if (store) mem[wr_ptr_cur_q[ADDR_WIDTH-1:0]] <= {input_axis_tlast, input_axis_tuser, input_axis_tdata};
    end
    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            state_q            <= WRITE;
            wr_ptr_q           <= '0;
            wr_ptr_cur_q       <= '0;
            rd_ptr_q           <= '0;
            output_axis_tdata  <= '0;
            output_axis_tvalid <= 1'b0;
            output_axis_tlast  <= 1'b0;
            output_axis_tuser  <= 1'b0;
            overflow           <= 1'b0;
            bad_frame          <= 1'b0;
            good_frame         <= 1'b0;
        end else begin
            overflow   <= 1'b0;
            bad_frame  <= 1'b0;
            good_frame <= 1'b0;
            if (store) begin
                wr_ptr_cur_q <= wr_ptr_cur_q + 1'b1;
                if (FRAME_MODE == 0 || input_axis_tlast) begin
                    if (FRAME_MODE != 0 && DROP_BAD_FRAME != 0 && input_axis_tuser) begin
                        wr_ptr_cur_q <= wr_ptr_q;
                        bad_frame    <= 1'b1;
                    end else begin
                        wr_ptr_q   <= wr_ptr_cur_q + 1'b1;
                        good_frame <= input_axis_tlast;
                    end
                end
            end else if (accept) begin
                // Only reachable in frame mode: beat hit a full buffer or we are already dropping.
                wr_ptr_cur_q <= wr_ptr_q;
                overflow     <= input_axis_tlast;
                state_q      <= input_axis_tlast ? WRITE : DROP;
            end
            if (rd_en) begin
                {output_axis_tlast, output_axis_tuser, output_axis_tdata} <= mem[rd_ptr_q[ADDR_WIDTH-1:0]];
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (out_adv) output_axis_tvalid <= ~empty;
        end
    end
endmodule

// File: tb/tb_axis_frame_fifo.sv
// tb_axis_frame_fifo: directed checks of a plain FIFO instance (a_) and a frame-mode
// instance with bad-frame and drop-when-full enabled (b_).
module tb_axis_frame_fifo;
    logic clk = 1'b0;
    logic async_rst = 1'b1;
    bit   rnd = 1'b0;
    int   checks = 0, failures = 0;
    logic [7:0] a_itdata, a_otdata, b_itdata, b_otdata;
    logic a_itvalid, a_itready, a_itlast, a_ituser, a_otvalid, a_otready, a_otlast, a_otuser;
    logic b_itvalid, b_itready, b_itlast, b_ituser, b_otvalid, b_otready, b_otlast, b_otuser;
    logic [3:0] a_cnt, b_cnt;
    logic a_af, a_ovf, a_bad, a_good, b_af, b_ovf, b_bad, b_good;
    logic [8:0] a_q[$], b_q[$];
    int b_good_n, b_bad_n, b_ovf_n;

    always #5 clk = ~clk;

    axis_frame_fifo #(.ADDR_WIDTH(3), .DATA_WIDTH(8)) u_a (
        .clk(clk), .async_rst(async_rst),
        .input_axis_tdata(a_itdata), .input_axis_tvalid(a_itvalid), .input_axis_tready(a_itready),
        .input_axis_tlast(a_itlast), .input_axis_tuser(a_ituser),
        .output_axis_tdata(a_otdata), .output_axis_tvalid(a_otvalid), .output_axis_tready(a_otready),
        .output_axis_tlast(a_otlast), .output_axis_tuser(a_otuser),
        .count(a_cnt), .almost_full(a_af), .overflow(a_ovf), .bad_frame(a_bad), .good_frame(a_good));

    axis_frame_fifo #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .FRAME_MODE(1), .DROP_BAD_FRAME(1), .DROP_WHEN_FULL(1)) u_b (
        .clk(clk), .async_rst(async_rst),
        .input_axis_tdata(b_itdata), .input_axis_tvalid(b_itvalid), .input_axis_tready(b_itready),
        .input_axis_tlast(b_itlast), .input_axis_tuser(b_ituser),
        .output_axis_tdata(b_otdata), .output_axis_tvalid(b_otvalid), .output_axis_tready(b_otready),
        .output_axis_tlast(b_otlast), .output_axis_tuser(b_otuser),
        .count(b_cnt), .almost_full(b_af), .overflow(b_ovf), .bad_frame(b_bad), .good_frame(b_good));

    // Outputs are stable from one posedge to the next, so the negedge view is what transfers.
    always @(negedge clk) begin
        if (a_otvalid && a_otready) a_q.push_back({a_otlast, a_otdata});
        if (b_otvalid && b_otready) b_q.push_back({b_otlast, b_otdata});
        b_good_n += int'(b_good);
        b_bad_n  += int'(b_bad);
        b_ovf_n  += int'(b_ovf);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        if (rnd) a_otready = 1'($urandom_range(0, 1));
    endtask

    task automatic a_send(input logic [7:0] d, input logic l);
        a_itdata = d; a_itlast = l; a_itvalid = 1'b1;
        for (int n = 0; n < 64 && !a_itready; n++) tick;
        check("a_accept_timeout", a_itready, 1);
        tick;
    endtask

    task automatic b_beat(input logic [7:0] d, input logic l, input logic u);
        b_itdata = d; b_itlast = l; b_ituser = u; b_itvalid = 1'b1;
        check("b_tready", b_itready, 1);
        tick;
    endtask

    task automatic b_clear;
        b_q.delete(); b_good_n = 0; b_bad_n = 0; b_ovf_n = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        {a_itdata, a_itvalid, a_itlast, a_ituser, a_otready} = '0;
        {b_itdata, b_itvalid, b_itlast, b_ituser} = '0;
        b_otready = 1'b1;
        b_clear();
        repeat (2) @(posedge clk);
        #1;
        check("rst_a_tvalid", a_otvalid, 0);
        check("rst_a_count", a_cnt, 0);
        check("rst_a_af", a_af, 0);
        check("rst_a_tready", a_itready, 0);
        check("rst_b_tready", b_itready, 0);
        check("rst_b_tvalid", b_otvalid, 0);
        async_rst = 1'b0;
        #1;
        check("rel_a_tready", a_itready, 1);
        check("rel_b_tready", b_itready, 1);

        // plain FIFO: fill with output stalled
        for (int i = 1; i <= 9; i++) begin
            a_send(8'(i), i == 9);
            if (i == 1) check("a_lat_beat1", a_otvalid, 0);
            if (i == 2) check("a_lat_beat2", a_otvalid, 1);
            if (i == 4) begin check("a_cnt4", a_cnt, 3); check("a_af4", a_af, 0); end
            if (i == 5) begin check("a_cnt5", a_cnt, 4); check("a_af5", a_af, 1); end
        end
        a_itvalid = 1'b0;
        check("a_good_last", a_good, 1);
        check("a_full_tready", a_itready, 0);
        check("a_full_count", a_cnt, 8);
        check("a_full_af", a_af, 1);
        check("a_head_data", a_otdata, 1);
        tick;
        check("a_good_pulse_end", a_good, 0);
        check("a_hold_data", a_otdata, 1);
        check("a_hold_valid", a_otvalid, 1);
        a_q.delete();
        a_otready = 1'b1;
        repeat (12) tick;
        check("a_drain_n", a_q.size(), 9);
        for (int i = 0; i < 9 && i < a_q.size(); i++) check("a_drain_beat", a_q[i], {i == 8, 8'(i + 1)});
        check("a_drain_valid", a_otvalid, 0);
        check("a_drain_count", a_cnt, 0);
        check("a_ovf_quiet", a_ovf, 0);

        // frame mode: 3-beat good frame
        b_clear();
        b_beat(8'hA0, 0, 0);
        check("b1_valid0", b_otvalid, 0);
        b_beat(8'hA1, 0, 0);
        check("b1_valid1", b_otvalid, 0);
        b_beat(8'hA2, 1, 0);
        b_itvalid = 1'b0;
        check("b1_good", b_good, 1);
        check("b1_valid_tlast_edge", b_otvalid, 0);
        check("b1_count", b_cnt, 3);
        tick;
        check("b1_valid_after", b_otvalid, 1);
        check("b1_first_data", b_otdata, 8'hA0);
        check("b1_good_end", b_good, 0);
        repeat (4) tick;
        check("b1_n", b_q.size(), 3);
        if (b_q.size() == 3) begin
            check("b1_d0", b_q[0], 9'h0A0);
            check("b1_d1", b_q[1], 9'h0A1);
            check("b1_d2", b_q[2], 9'h1A2);
        end
        check("b1_good_n", b_good_n, 1);
        check("b1_count_end", b_cnt, 0);

        // bad frame then good frame
        b_clear();
        for (int i = 0; i < 4; i++) b_beat(8'hB0 + 8'(i), i == 3, i == 3);
        check("b2_bad", b_bad, 1);
        check("b2_count", b_cnt, 0);
        b_beat(8'h10, 0, 0);
        b_beat(8'h11, 1, 0);
        b_itvalid = 1'b0;
        repeat (5) tick;
        check("b2_n", b_q.size(), 2);
        if (b_q.size() == 2) begin
            check("b2_d0", b_q[0], 9'h010);
            check("b2_d1", b_q[1], 9'h111);
        end
        check("b2_bad_n", b_bad_n, 1);
        check("b2_good_n", b_good_n, 1);
        check("b2_count_end", b_cnt, 0);

        // oversized frame dropped without back-pressure
        b_clear();
        for (int i = 0; i < 12; i++) begin
            b_beat(8'hC0 + 8'(i), i == 11, 0);
            if (i == 10) check("b3_ovf_early", b_ovf, 0);
        end
        check("b3_ovf", b_ovf, 1);
        check("b3_count", b_cnt, 0);
        b_beat(8'h55, 0, 0);
        b_beat(8'h66, 1, 0);
        b_itvalid = 1'b0;
        repeat (5) tick;
        check("b3_n", b_q.size(), 2);
        if (b_q.size() == 2) begin
            check("b3_d0", b_q[0], 9'h055);
            check("b3_d1", b_q[1], 9'h166);
        end
        check("b3_ovf_n", b_ovf_n, 1);
        check("b3_good_n", b_good_n, 1);

        // pointer wrap with random output back-pressure
        a_q.delete();
        rnd = 1'b1;
        for (int i = 0; i < 40; i++) a_send(8'(i), 1);
        a_itvalid = 1'b0;
        rnd = 1'b0;
        a_otready = 1'b1;
        repeat (20) tick;
        check("wrap_n", a_q.size(), 40);
        for (int i = 0; i < 40 && i < a_q.size(); i++) check("wrap_beat", a_q[i], {1'b1, 8'(i)});

        // asynchronous reset mid-traffic
        a_otready = 1'b0;
        a_q.delete();
        for (int i = 0; i < 5; i++) a_send(8'h20 + 8'(i), 0);
        a_itvalid = 1'b0;
        check("r_a_count_pre", a_cnt, 4);
        b_clear();
        for (int i = 0; i < 3; i++) b_beat(8'h30 + 8'(i), 0, 0);
        b_itvalid = 1'b0;
        #2 async_rst = 1'b1;
        #1;
        check("r_a_valid", a_otvalid, 0);
        check("r_a_count", a_cnt, 0);
        check("r_b_tready", b_itready, 0);
        #1 async_rst = 1'b0;
        tick;
        b_beat(8'h77, 1, 0);
        b_itvalid = 1'b0;
        a_otready = 1'b1;
        repeat (4) tick;
        check("r_b_n", b_q.size(), 1);
        if (b_q.size() == 1) check("r_b_d0", b_q[0], 9'h177);
        check("r_a_n", a_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
